// File: rtl/clink_frame_capture_ctrl.sv
// clink_frame_capture_ctrl: aligns to Camera Link frames, packs port-A pixels into wide words and streams them to DRAM
module clink_frame_capture_ctrl #(
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 128,
  parameter int PIX_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [CNT_WIDTH-1:0]  cfg_frame_num,
  input  logic [CNT_WIDTH-1:0]  cfg_line_num,
  input  logic [CNT_WIDTH-1:0]  cfg_pixel_num,
  input  logic                  deser_locked,
  input  logic                  pix_valid,
  input  logic                  pix_fval,
  input  logic                  pix_lval,
  input  logic                  pix_dval,
  input  logic [PIX_WIDTH-1:0]  pix_a,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic                  err_overflow,
  output logic                  err_size,
  output logic                  err_lock
);
  localparam int BYTES = DATA_WIDTH / PIX_WIDTH;
  localparam int IW    = $clog2(BYTES);

  typedef enum logic [2:0] {
    st_idle, st_wait_lock, st_wait_fval_low, st_wait_frame, st_capture, st_flush, st_done
  } state_t;

  state_t                  state, state_nx;
  logic                    prev_fval, prev_lval;
  logic [IW-1:0]           idx;
  logic [DATA_WIDTH-1:0]   pack_buf, cur_word;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [CNT_WIDTH-1:0]    line_cnt, pix_line, lines_total, frame_inc;
  logic                    in_run, lock_lost, live, frame_begin, in_cap, frame_end, line_end;
  logic                    accept, word_done, flush, part_emit, emit, frame_last, start_ok;

  assign in_run      = state inside {st_wait_fval_low, st_wait_frame, st_capture, st_flush};
  assign lock_lost   = !cfg_abort && in_run && !deser_locked;
  assign live        = !cfg_abort && !lock_lost;
  assign start_ok    = state == st_idle && cfg_start && !cfg_abort;
  // a frame only begins on a sampled fval rising edge, so capture never starts mid-frame
  assign frame_begin = live && state == st_wait_frame && pix_valid && pix_fval && !prev_fval;
  assign in_cap      = live && state == st_capture && pix_valid;
  assign frame_end   = in_cap && !pix_fval;
  assign line_end    = in_cap && prev_lval && !(pix_fval && pix_lval);
  assign accept      = (frame_begin || in_cap) && pix_fval && pix_lval && pix_dval;
  assign word_done   = accept && idx == IW'(BYTES - 1);
  assign flush       = live && state == st_flush;
  assign part_emit   = flush && idx != '0;
  assign emit        = word_done || part_emit;
  assign frame_inc   = frame_cnt + 1'b1;
  assign frame_last  = frame_inc == cfg_frame_num && cfg_frame_num != '0;
  assign lines_total = line_cnt + CNT_WIDTH'(line_end);

  always_comb begin
    cur_word = pack_buf;
    cur_word[idx*PIX_WIDTH +: PIX_WIDTH] = pix_a;
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset)
    if (s_axi_areset) state <= st_idle;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      st_idle:          state_nx = cfg_start ? st_wait_lock : st_idle;
      st_wait_lock:     state_nx = deser_locked ? st_wait_fval_low : st_wait_lock;
      st_wait_fval_low: state_nx = (pix_valid && !pix_fval) ? st_wait_frame : st_wait_fval_low;
      st_wait_frame:    state_nx = frame_begin ? st_capture : st_wait_frame;
      st_capture:       state_nx = frame_end ? st_flush : st_capture;
      st_flush:         state_nx = frame_last ? st_done : st_wait_frame;
      default:          state_nx = st_idle;
    endcase
    state_nx = lock_lost ? st_wait_lock : state_nx;
    state_nx = cfg_abort ? st_idle : state_nx;
  end

  always_comb begin
    busy = state != st_idle;
    done = state == st_done;
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      prev_fval    <= 1'b0;
      prev_lval    <= 1'b0;
      idx          <= '0;
      pack_buf     <= '0;
      addr_reg     <= '0;
      line_cnt     <= '0;
      pix_line     <= '0;
      wr_valid     <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      frame_cnt    <= '0;
      err_overflow <= 1'b0;
      err_size     <= 1'b0;
      err_lock     <= 1'b0;
    end else begin
      if (pix_valid) begin
        prev_fval <= pix_fval;
        prev_lval <= pix_lval;
      end
      if (cfg_abort || lock_lost || flush) begin
        pack_buf <= '0;
        idx      <= '0;
      end else if (accept) begin
        pack_buf <= word_done ? '0 : cur_word;
        idx      <= idx + 1'b1;
      end
      // the address advances even for a dropped word so DRAM layout stays positional
      if (emit) begin
        addr_reg <= addr_reg + ADDR_WIDTH'(BYTES);
        if (wr_valid && !wr_ready) err_overflow <= 1'b1;
        else begin
          wr_valid <= 1'b1;
          wr_addr  <= addr_reg;
          wr_data  <= word_done ? cur_word : pack_buf;
        end
      end else if (wr_ready) wr_valid <= 1'b0;
      if (lock_lost) err_lock <= 1'b1;
      if ((line_end && pix_line != cfg_pixel_num) || (frame_end && lines_total != cfg_line_num))
        err_size <= 1'b1;
      if (frame_begin) begin
        line_cnt <= '0;
        pix_line <= CNT_WIDTH'(accept);
      end else if (line_end) begin
        line_cnt <= line_cnt + 1'b1;
        pix_line <= '0;
      end else if (accept) pix_line <= pix_line + 1'b1;
      if (flush) frame_cnt <= frame_inc;
      if (start_ok) begin
        addr_reg     <= cfg_base_addr & ~ADDR_WIDTH'(BYTES - 1);
        frame_cnt    <= '0;
        err_overflow <= 1'b0;
        err_size     <= 1'b0;
        err_lock     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_clink_frame_capture_ctrl.sv
// tb_clink_frame_capture_ctrl: randomized directed scenarios checked against a byte-queue frame model
module tb_clink_frame_capture_ctrl;
  localparam int AW = 48, DW = 128, CW = 16;

  logic          clk = 1'b0, rst = 1'b1;
  logic          cfg_start = 0, cfg_abort = 0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [CW-1:0] cfg_frame_num = '0, cfg_line_num = '0, cfg_pixel_num = '0;
  logic          deser_locked = 1'b1, pix_valid = 0, pix_fval = 0, pix_lval = 0, pix_dval = 0;
  logic [7:0]    pix_a = '0;
  logic          wr_valid, wr_ready = 1'b1, busy, done, err_overflow, err_size, err_lock;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [CW-1:0] frame_cnt;

  always #5 clk = ~clk;

  clink_frame_capture_ctrl dut (
    .s_axi_aclk(clk), .s_axi_areset(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_base_addr(cfg_base_addr), .cfg_frame_num(cfg_frame_num), .cfg_line_num(cfg_line_num),
    .cfg_pixel_num(cfg_pixel_num), .deser_locked(deser_locked), .pix_valid(pix_valid),
    .pix_fval(pix_fval), .pix_lval(pix_lval), .pix_dval(pix_dval), .pix_a(pix_a),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .frame_cnt(frame_cnt), .err_overflow(err_overflow),
    .err_size(err_size), .err_lock(err_lock)
  );

  int total = 0, bad = 0, done_cnt = 0, ready_mode = 1, wcnt = 0, d0 = 0;
  logic [AW-1:0] base_al;
  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_data[$];
  logic [DW-1:0] exp_words[$];
  logic [7:0]    fb[$];

  // stream sink: records accepted words; random ready never stalls a word more than two cycles
  always @(posedge clk) begin
    if (done) done_cnt++;
    if (wr_valid && wr_ready) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
    end
    wcnt = (wr_valid && !wr_ready) ? wcnt + 1 : 0;
    #1;
    wr_ready = ready_mode == 0 ? 1'b0 : ready_mode == 1 ? 1'b1 : ($urandom_range(1, 0) == 1 || wcnt >= 2);
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic f, input logic l, input logic d, input logic [7:0] a);
    while ($urandom_range(3, 0) == 0) begin
      pix_valid = 0; pix_fval = 1'($urandom); pix_lval = 1'($urandom);
      pix_dval = 1'($urandom); pix_a = 8'($urandom);
      idle(1);
    end
    pix_valid = 1; pix_fval = f; pix_lval = l; pix_dval = d; pix_a = a;
    idle(1);
    pix_valid = 0;
  endtask

  task automatic pix(input bit cap);
    logic [7:0] a;
    a = 8'($urandom);
    while ($urandom_range(4, 0) == 0) smp(1, 1, 0, 8'($urandom));
    smp(1, 1, 1, a);
    if (cap) fb.push_back(a);
  endtask

  task automatic send_line(input int n, input bit cap);
    repeat (n) pix(cap);
    repeat (3) smp(1, 0, 0, 8'h00);
  endtask

  // model: a frame's accepted bytes in arrival order, 16 per word, tail zero-padded or discarded
  task automatic model_end(input bit keep);
    logic [DW-1:0] w;
    while (fb.size() >= 16) begin
      w = '0;
      for (int i = 0; i < 16; i++) w[8*i +: 8] = fb.pop_front();
      exp_words.push_back(w);
    end
    if (keep && fb.size() > 0) begin
      w = '0;
      for (int i = 0; fb.size() > 0; i++) w[8*i +: 8] = fb.pop_front();
      exp_words.push_back(w);
    end
    fb.delete();
  endtask

  task automatic send_frame(input int lines, input int ppl, input bit cap);
    repeat (2) smp(0, 0, 0, 8'h00);
    repeat (2) smp(1, 0, 0, 8'h00);
    repeat (lines) send_line(ppl, cap);
    repeat (3) smp(0, 0, 0, 8'h00);
    if (cap) model_end(1);
  endtask

  task automatic frame_head();
    repeat (2) smp(0, 0, 0, 8'h00);
    repeat (2) smp(1, 0, 0, 8'h00);
  endtask

  task automatic start_cap(input int fn, input int ln, input int pn, input logic [AW-1:0] base);
    got_addr.delete(); got_data.delete(); exp_words.delete(); fb.delete();
    base_al = {base[AW-1:4], 4'h0};
    cfg_frame_num = CW'(fn); cfg_line_num = CW'(ln); cfg_pixel_num = CW'(pn); cfg_base_addr = base;
    cfg_start = 1; idle(1); cfg_start = 0;
    idle(3);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && busy; i++) idle(1);
    idle(6);
    chk("idle_wait", busy, 0);
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_count"}, got_data.size(), exp_words.size());
    for (int i = 0; i < exp_words.size() && i < got_data.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_data[i], exp_words[i]);
      chk($sformatf("%s_addr%0d", tag, i), got_addr[i], base_al + AW'(16 * i));
    end
  endtask

  initial begin
    idle(3);
    chk("rst_flags", {wr_valid, busy, done, err_overflow, err_size, err_lock, frame_cnt}, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    rst = 0;
    idle(2);

    // 1: one 16x16 frame, always ready
    ready_mode = 1; d0 = done_cnt;
    start_cap(1, 16, 16, 48'h4_0000_0007);
    send_frame(16, 16, 1);
    wait_idle();
    check_words("s1");
    chk("s1_last_addr", got_addr.size() == 16 ? got_addr[15] : '0, 48'h4_0000_00F0);
    chk("s1_done", done_cnt - d0, 1);
    chk("s1_errs", {err_overflow, err_size, err_lock}, 0);
    chk("s1_fcnt", frame_cnt, 1);

    // 2: 20 pixels x 3 lines with random ready, padded tail
    ready_mode = 2;
    start_cap(1, 3, 20, 48'h4_0000_1000);
    send_frame(3, 20, 1);
    wait_idle();
    check_words("s2");
    chk("s2_pad", got_data.size() >= 4 ? DW'(got_data[3][127:96]) : {DW{1'bx}}, 0);
    chk("s2_errs", {err_overflow, err_size, err_lock}, 0);

    // 3: sink stalled across two completions
    ready_mode = 0;
    start_cap(1, 2, 16, 48'h4_0000_2000);
    send_frame(2, 16, 1);
    wait_idle();
    idle(40);
    chk("s3_none", got_data.size(), 0);
    chk("s3_valid", wr_valid, 1);
    chk("s3_hold_data", wr_data, exp_words[0]);
    chk("s3_hold_addr", wr_addr, base_al);
    chk("s3_ovf", err_overflow, 1);
    ready_mode = 1;
    idle(4);
    chk("s3_count", got_data.size(), 1);
    chk("s3_word", got_data.size() > 0 ? got_data[0] : {DW{1'bx}}, exp_words[0]);
    chk("s3_drained", wr_valid, 0);

    // 4: armed in the middle of a frame
    ready_mode = 1;
    repeat (3) smp(1, 1, 1, 8'($urandom));
    start_cap(1, 2, 16, 48'h4_0000_3000);
    repeat (12) smp(1, 1, 1, 8'($urandom));
    repeat (3) smp(1, 0, 0, 8'h00);
    send_frame(2, 16, 1);
    wait_idle();
    check_words("s4");
    chk("s4_errs", {err_overflow, err_size, err_lock}, 0);

    // 5: lock loss mid-frame, relock mid-frame, recapture
    ready_mode = 2; d0 = done_cnt;
    start_cap(2, 4, 16, 48'h4_0000_4000);
    send_frame(4, 16, 1);
    frame_head();
    send_line(16, 1);
    repeat (8) pix(1);
    deser_locked = 0;
    model_end(0);
    idle(4);
    chk("s5_lock", err_lock, 1);
    chk("s5_fcnt_hold", frame_cnt, 1);
    chk("s5_busy", busy, 1);
    repeat (8) pix(0);
    deser_locked = 1;
    repeat (4) pix(0);
    repeat (3) smp(1, 0, 0, 8'h00);
    send_frame(4, 16, 1);
    wait_idle();
    check_words("s5");
    chk("s5_fcnt", frame_cnt, 2);
    chk("s5_done", done_cnt - d0, 1);
    chk("s5_lock_sticky", err_lock, 1);

    // 6: short frame then a good one, two-frame run
    ready_mode = 2; d0 = done_cnt;
    start_cap(2, 16, 16, 48'h4_0000_5000);
    send_frame(15, 16, 1);
    idle(5);
    chk("s6_fcnt1", frame_cnt, 1);
    chk("s6_nodone", done_cnt - d0, 0);
    chk("s6_size", err_size, 1);
    send_frame(16, 16, 1);
    wait_idle();
    check_words("s6");
    chk("s6_fcnt2", frame_cnt, 2);
    chk("s6_done", done_cnt - d0, 1);

    // 7: continuous run, wrong pixel count, abort mid-frame, start+abort together
    ready_mode = 2; d0 = done_cnt;
    start_cap(0, 2, 17, 48'h4_0000_6000);
    send_frame(2, 16, 1);
    send_frame(2, 16, 1);
    frame_head();
    repeat (8) pix(1);
    chk("s7_fcnt", frame_cnt, 2);
    chk("s7_busy", busy, 1);
    chk("s7_size", err_size, 1);
    cfg_abort = 1; idle(1); cfg_abort = 0;
    model_end(0);
    idle(6);
    chk("s7_idle", busy, 0);
    chk("s7_nodone", done_cnt - d0, 0);
    check_words("s7");
    cfg_start = 1; cfg_abort = 1; idle(1); cfg_start = 0; cfg_abort = 0;
    idle(2);
    chk("s7_abort_wins", busy, 0);
    chk("s7_fcnt_kept", frame_cnt, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
